// File: rtl/fifo_packer_pkg.sv
// ============================================================================
//  Module      : fifo_packer_pkg
//  Description : Shared width/slot helpers for the FIFO word packer family.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_packer_pkg;

    // Counter wide enough to hold 0..n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // LSB index of slot k when slots fill from the MSB end of a w-bit word.
    function automatic int slot_lsb(input int k, input int w, input int b);
        return w - (k + 1) * b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_packer_out_reg.sv
// ============================================================================
//  Module      : fifo_packer_out_reg
//  Description : Single-entry val/rdy output register with load/out_free.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_packer_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_free,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_val,
    input  logic                  i_rdy
);

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_val;

    // The slot can take a new entry if empty or if the current one leaves now.
    assign o_free = !r_val | i_rdy;
    assign o_data = r_data;
    assign o_val  = r_val;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data <= '0;
            r_val  <= 1'b0;
        end else if (i_load) begin
            r_data <= i_data;
            r_val  <= 1'b1;
        end else if (i_rdy) begin
            r_val  <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ============================================================================
//  Module      : fifo_word_packer
//  Description : Packs narrow messages MSB-first into a zero-padded word with
//                flush support; optional resp_cnt via FIFO_WORD_PACKER_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_word_packer
    import fifo_packer_pkg::*;
#(
    parameter int P_BIT_WIDTH      = 3,
    parameter int P_NUM_CONCAT     = 4,
    parameter int P_FULL_BIT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [P_BIT_WIDTH-1:0]               req_msg,
    input  logic                                 req_val,
    output logic                                 req_rdy,
    input  logic                                 flush,
    output logic [P_FULL_BIT_WIDTH-1:0]          resp_msg,
    output logic                                 resp_val,
`ifdef FIFO_WORD_PACKER_COUNT_EN
    output logic [cnt_width(P_NUM_CONCAT)-1:0]   resp_cnt,
`endif
    input  logic                                 resp_rdy
);

    localparam int                 c_cnt_w    = cnt_width(P_NUM_CONCAT);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(P_NUM_CONCAT);
`ifdef FIFO_WORD_PACKER_COUNT_EN
    localparam int                 c_data_w   = P_FULL_BIT_WIDTH + c_cnt_w;
`else
    localparam int                 c_data_w   = P_FULL_BIT_WIDTH;
`endif

    logic [P_FULL_BIT_WIDTH-1:0] r_acc;
    logic [c_cnt_w-1:0]          r_cnt;
    logic                        r_flush_pend;

    logic                        w_fire_in;
    logic                        w_out_free;
    logic [P_FULL_BIT_WIDTH-1:0] w_acc_ins;
    logic [c_cnt_w-1:0]          w_cnt_inc;
    logic                        w_full_now;
    logic                        w_flush_take;
    logic                        w_complete_now;
    logic                        w_pending;
    logic                        w_load;
    logic [P_FULL_BIT_WIDTH-1:0] w_load_msg;
    logic [c_cnt_w-1:0]          w_load_cnt;
    logic [c_data_w-1:0]         w_load_data;
    logic [c_data_w-1:0]         w_out_data;
    logic [P_FULL_BIT_WIDTH-1:0] w_acc_nxt;
    logic [c_cnt_w-1:0]          w_cnt_nxt;
    logic                        w_flush_pend_nxt;

    // Stalled completed words (full or flushed) block further input.
    assign w_pending = (r_cnt == c_full_cnt) | r_flush_pend;
    assign req_rdy   = !w_pending;
    assign w_fire_in = req_val & req_rdy;
    assign w_cnt_inc = r_cnt + c_cnt_w'(w_fire_in);

    always_comb begin
        w_acc_ins = r_acc;
        if (w_fire_in) begin
            for (int k = 0; k < P_NUM_CONCAT; k++) begin
                if (r_cnt == c_cnt_w'(k)) begin
                    w_acc_ins[slot_lsb(k, P_FULL_BIT_WIDTH, P_BIT_WIDTH) +: P_BIT_WIDTH] = req_msg;
                end
            end
        end
    end

    // A flush only counts if there is something to emit, including this cycle's message.
    assign w_full_now     = w_fire_in & (w_cnt_inc == c_full_cnt);
    assign w_flush_take   = flush & req_rdy & ((r_cnt != '0) | w_fire_in);
    assign w_complete_now = w_full_now | w_flush_take;
    assign w_load         = (w_complete_now | w_pending) & w_out_free;

    always_comb begin
        w_load_msg = w_acc_ins;
        w_load_cnt = w_cnt_inc;
        if (w_pending) begin
            w_load_msg = r_acc;
            w_load_cnt = r_cnt;
        end
    end

`ifdef FIFO_WORD_PACKER_COUNT_EN
    assign w_load_data = {w_load_cnt, w_load_msg};
    assign resp_cnt    = w_out_data[c_data_w-1 -: c_cnt_w];
`else
    assign w_load_data = w_load_msg;
`endif
    assign resp_msg = w_out_data[P_FULL_BIT_WIDTH-1:0];

    always_comb begin
        w_acc_nxt        = w_acc_ins;
        w_cnt_nxt        = w_cnt_inc;
        w_flush_pend_nxt = r_flush_pend;
        if (w_load) begin
            w_acc_nxt        = '0;
            w_cnt_nxt        = '0;
            w_flush_pend_nxt = 1'b0;
        end else if (w_flush_take) begin
            w_flush_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_acc        <= w_acc_nxt;
            r_cnt        <= w_cnt_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    fifo_packer_out_reg #(
        .DATA_WIDTH (c_data_w)
    ) u_out_reg (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_data (w_load_data),
        .o_free (w_out_free),
        .o_data (w_out_data),
        .o_val  (resp_val),
        .i_rdy  (resp_rdy)
    );

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================================
//  Module      : tb_fifo_word_packer
//  Description : Directed self-checking bench with a queue-based packing model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_word_packer;

    localparam int c_b  = 3;
    localparam int c_n  = 4;
    localparam int c_w  = 16;

    logic            clk;
    logic            reset;
    logic [c_b-1:0]  req_msg;
    logic            req_val;
    logic            req_rdy;
    logic            flush;
    logic [c_w-1:0]  resp_msg;
    logic            resp_val;
    logic            resp_rdy;
`ifdef FIFO_WORD_PACKER_COUNT_EN
    logic [2:0]      resp_cnt;
`endif

    fifo_word_packer dut (
        .clk      (clk),
        .reset    (reset),
        .req_msg  (req_msg),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .flush    (flush),
        .resp_msg (resp_msg),
        .resp_val (resp_val),
`ifdef FIFO_WORD_PACKER_COUNT_EN
        .resp_cnt (resp_cnt),
`endif
        .resp_rdy (resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: messages collect in a list; each completed word joins a queue of
    // words owed to the consumer. At most two can be owed (output + assembly).
    typedef struct {
        logic [c_w-1:0] w;
        int             n;
    } word_t;

    logic [c_b-1:0] part[$];
    word_t          expq[$];
    bit             live = 0;

    always @(posedge clk) begin
        bit    m_rdy;
        word_t nw;
        if (!reset) begin
            part.delete();
            expq.delete();
            live = 1;
        end else if (live) begin
            m_rdy = (expq.size() < 2);
            if (expq.size() > 0 && resp_rdy) void'(expq.pop_front());
            if (req_val && m_rdy) part.push_back(req_msg);
            if (part.size() == c_n || (flush && m_rdy && part.size() > 0)) begin
                nw.w = '0;
                foreach (part[k]) nw.w |= c_w'(part[k]) << (c_w - (k + 1) * c_b);
                nw.n = part.size();
                expq.push_back(nw);
                part.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("cmp_resp_val", {31'b0, resp_val}, {31'b0, expq.size() > 0});
            check("cmp_req_rdy", {31'b0, req_rdy}, {31'b0, expq.size() < 2});
            if (resp_val && expq.size() > 0) begin
                check("cmp_resp_msg", {16'b0, resp_msg}, {16'b0, expq[0].w});
`ifdef FIFO_WORD_PACKER_COUNT_EN
                check("cmp_resp_cnt", {29'b0, resp_cnt}, 32'(expq[0].n));
`endif
            end
        end
    end

    task automatic step(input logic v, input logic [c_b-1:0] m, input logic f);
        req_val = v;
        req_msg = m;
        flush   = f;
        @(posedge clk);
        #1;
        req_val = 1'b0;
        flush   = 1'b0;
    endtask

    int          idx;
    int          accepts;
    logic        was_rdy;
    logic [2:0]  t1_msgs [4];
    logic [2:0]  rnd_msgs [16];

    initial begin
        reset    = 1'b0;
        req_val  = 1'b0;
        req_msg  = '0;
        flush    = 1'b0;
        resp_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_resp_val", {31'b0, resp_val}, 32'd0);
        check("reset_resp_msg", {16'b0, resp_msg}, 32'd0);
        check("reset_req_rdy", {31'b0, req_rdy}, 32'd1);
        reset = 1'b1;
        step(1'b0, '0, 1'b0);

        // Full word, no backpressure
        t1_msgs = '{3'b101, 3'b011, 3'b110, 3'b001};
        for (int i = 0; i < 4; i++) begin
            check("full_req_rdy", {31'b0, req_rdy}, 32'd1);
            step(1'b1, t1_msgs[i], 1'b0);
        end
        check("full_resp_val", {31'b0, resp_val}, 32'd1);
        check("full_resp_msg", {16'b0, resp_msg}, 32'hAF10);
`ifdef FIFO_WORD_PACKER_COUNT_EN
        check("full_resp_cnt", {29'b0, resp_cnt}, 32'd4);
`endif
        check("full_req_rdy_after", {31'b0, req_rdy}, 32'd1);
        step(1'b0, '0, 1'b0);

        // Flush of a partial word, then a flush with nothing buffered
        step(1'b1, 3'b111, 1'b0);
        step(1'b1, 3'b010, 1'b0);
        step(1'b0, '0, 1'b1);
        check("flush_resp_val", {31'b0, resp_val}, 32'd1);
        check("flush_resp_msg", {16'b0, resp_msg}, 32'hE800);
`ifdef FIFO_WORD_PACKER_COUNT_EN
        check("flush_resp_cnt", {29'b0, resp_cnt}, 32'd2);
`endif
        step(1'b0, '0, 1'b1);
        check("flush_empty_val", {31'b0, resp_val}, 32'd0);
        step(1'b0, '0, 1'b0);
        check("flush_empty_val2", {31'b0, resp_val}, 32'd0);

        // Flush together with a message: the message joins the word
        step(1'b1, 3'b100, 1'b0);
        step(1'b1, 3'b001, 1'b1);
        check("flushmsg_resp_val", {31'b0, resp_val}, 32'd1);
        check("flushmsg_resp_msg", {16'b0, resp_msg}, 32'h8400);
`ifdef FIFO_WORD_PACKER_COUNT_EN
        check("flushmsg_resp_cnt", {29'b0, resp_cnt}, 32'd2);
`endif
        step(1'b0, '0, 1'b0);

        // Backpressure: two words buffered, then drain
        resp_rdy = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            req_val = 1'b1;
            req_msg = idx[2:0];
            #0;
            was_rdy = req_rdy;
            @(posedge clk);
            #1;
            if (was_rdy) idx++;
        end
        req_val = 1'b0;
        check("bp_accepts", 32'(idx), 32'd8);
        check("bp_req_rdy", {31'b0, req_rdy}, 32'd0);
        check("bp_held_msg", {16'b0, resp_msg}, 32'h0530);
        step(1'b0, '0, 1'b0);
        check("bp_held_stable", {16'b0, resp_msg}, 32'h0530);
        resp_rdy = 1'b1;
        for (int c = 0; c < 40 && idx < 12; c++) begin
            req_val = 1'b1;
            req_msg = idx[2:0];
            #0;
            was_rdy = req_rdy;
            @(posedge clk);
            #1;
            if (c == 0) check("bp_second_word", {16'b0, resp_msg}, 32'h9770);
            if (was_rdy) idx++;
        end
        req_val = 1'b0;
        check("bp_resume_done", 32'(idx), 32'd12);
        repeat (3) step(1'b0, '0, 1'b0);
        check("bp_drained", {31'b0, resp_val}, 32'd0);

        // Streaming: one accept per cycle
        foreach (rnd_msgs[i]) rnd_msgs[i] = 3'($urandom_range(0, 7));
        accepts = 0;
        for (int i = 0; i < 16; i++) begin
            req_val = 1'b1;
            req_msg = rnd_msgs[i];
            #0;
            if (req_rdy) accepts++;
            @(posedge clk);
            #1;
        end
        req_val = 1'b0;
        check("stream_no_bubble", 32'(accepts), 32'd16);
        repeat (2) step(1'b0, '0, 1'b0);

        // Reset mid-word discards the partial data
        step(1'b1, 3'b111, 1'b0);
        step(1'b1, 3'b111, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_mid_resp_val", {31'b0, resp_val}, 32'd0);
        check("rst_mid_req_rdy", {31'b0, req_rdy}, 32'd1);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        step(1'b1, 3'b001, 1'b0);
        check("rst_clean_val", {31'b0, resp_val}, 32'd1);
        check("rst_clean_msg", {16'b0, resp_msg}, 32'h0010);
        repeat (2) step(1'b0, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
